// File: rtl/elevator_scheduler_if.sv
// Scheduler-to-display bundle: motion tick and call buttons in, pending mask,
// state code and current floor out.
interface elevator_scheduler_if #(
  parameter int FLOORS = 8
);
  localparam int FW = $clog2(FLOORS);

  logic              tick;
  logic [FLOORS-1:0] req;
  logic [FLOORS-1:0] destination;
  logic [1:0]        sim_state;
  logic [FW-1:0]     floor;

  modport master (
    output tick, req,
    input  destination, sim_state, floor
  );

  modport slave (
    input  tick, req,
    output destination, sim_state, floor
  );
endinterface

// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: latches floor calls, moves the car one floor
// per MOVE_TICKS ticks and opens the doors for DOOR_TICKS ticks at each call.
module elevator_scheduler #(
  parameter int FLOORS     = 8,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  elevator_scheduler_if.slave bus
);
  localparam int FW = $clog2(FLOORS);
  localparam int MW = $clog2(MOVE_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_DOOR = 2'b11
  } state_t;

  state_t            state_reg, state_next;
  logic [FW-1:0]     floor_reg, floor_next;
  logic [FLOORS-1:0] pending_reg, pending_next;
  logic [MW-1:0]     move_cnt_reg, move_cnt_next;
  logic [DW-1:0]     door_cnt_reg, door_cnt_next;
  logic              last_up_reg, last_up_next;

  logic [FLOORS-1:0] req_mask, above_bits, below_bits, clr_mask;
  logic              above, below, move_done, door_done;
  logic [FW-1:0]     floor_up, floor_down;

  // Calls arriving this cycle take part in every decision made on this edge.
  assign req_mask = pending_reg | bus.req;

  generate
    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_dir
      assign above_bits[gi] = req_mask[gi] && (FW'(gi) > floor_reg);
      assign below_bits[gi] = req_mask[gi] && (FW'(gi) < floor_reg);
    end
  endgenerate

  assign above      = |above_bits;
  assign below      = |below_bits;
  assign move_done  = bus.tick && (move_cnt_reg == MW'(MOVE_TICKS - 1));
  assign door_done  = bus.tick && (door_cnt_reg == DW'(DOOR_TICKS - 1));
  assign floor_up   = (floor_reg == FW'(FLOORS - 1)) ? floor_reg : floor_reg + FW'(1);
  assign floor_down = (floor_reg == '0) ? floor_reg : floor_reg - FW'(1);

  always_comb begin
    state_next    = state_reg;
    floor_next    = floor_reg;
    move_cnt_next = move_cnt_reg;
    door_cnt_next = door_cnt_reg;
    last_up_next  = last_up_reg;
    clr_mask      = '0;

    case (state_reg)
      ST_IDLE: begin
        if (req_mask[floor_reg]) state_next = ST_DOOR;
        else if (above)          state_next = ST_UP;
        else if (below)          state_next = ST_DOWN;
      end
      ST_UP: begin
        if (move_done) begin
          move_cnt_next = '0;
          floor_next    = floor_up;
          if (req_mask[floor_up]) state_next = ST_DOOR;
        end else if (bus.tick) begin
          move_cnt_next = move_cnt_reg + MW'(1);
        end
      end
      ST_DOWN: begin
        if (move_done) begin
          move_cnt_next = '0;
          floor_next    = floor_down;
          if (req_mask[floor_down]) state_next = ST_DOOR;
        end else if (bus.tick) begin
          move_cnt_next = move_cnt_reg + MW'(1);
        end
      end
      ST_DOOR: begin
        if (door_done) begin
          door_cnt_next = '0;
          if (last_up_reg && above)       state_next = ST_UP;
          else if (!last_up_reg && below) state_next = ST_DOWN;
          else if (above)                 state_next = ST_UP;
          else if (below)                 state_next = ST_DOWN;
          else                            state_next = ST_IDLE;
        end else if (bus.tick) begin
          door_cnt_next = door_cnt_reg + DW'(1);
        end
      end
    endcase

    if (state_next != state_reg) begin
      move_cnt_next = '0;
      door_cnt_next = '0;
    end
    if (state_next == ST_UP && state_reg != ST_UP)     last_up_next = 1'b1;
    if (state_next == ST_DOWN && state_reg != ST_DOWN) last_up_next = 1'b0;

    // The landing floor is cleared on the entry edge too, so the clear beats a same-floor call.
    if (state_next == ST_DOOR) clr_mask = FLOORS'(1) << floor_next;
    pending_next = req_mask & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      floor_reg    <= '0;
      pending_reg  <= '0;
      move_cnt_reg <= '0;
      door_cnt_reg <= '0;
      last_up_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      floor_reg    <= floor_next;
      pending_reg  <= pending_next;
      move_cnt_reg <= move_cnt_next;
      door_cnt_reg <= door_cnt_next;
      last_up_reg  <= last_up_next;
    end
  end

  assign bus.destination = pending_reg;
  assign bus.sim_state   = state_reg;
  assign bus.floor       = floor_reg;
endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Single-car elevator scheduler sitting directly upstream of the VGA display controller. It latches floor-call buttons into a pending-request mask and runs the car up and down through the floors. The doors open at every requested floor. It drives the `destination` mask and `sim_state` code that the display stage renders, and it advances on a divided-clock `tick` enable so the motion stays visible on screen.

## Interface
- `FLOORS`, 8: number of floors; sets the widths of `req`/`destination`; floor index width `FW = $clog2(FLOORS)`
- `MOVE_TICKS`, 2: ticks spent travelling between adjacent floors (≥1)
- `DOOR_TICKS`, 4: ticks the doors stay open (≥1)

- `clk`  in  1  system clock (pixel-clock domain); all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-low
- `tick`  in  1  one-cycle motion enable from the clock divider
- `req`  in  FLOORS  call buttons, level-sampled every cycle; bit i is floor i
- `destination`  out  FLOORS  registered pending-request mask, fed to the display
- `sim_state`  out  2  registered state code: 00 IDLE, 01 UP, 10 DOWN, 11 DOOR
- `floor`  out  FW  registered current floor index

## Operation
- Reset (`rst`=0 at an edge) clears the following. It takes priority over everything, including mid-move or mid-door.
  - `pending`=0, `floor`=0, `sim_state`=IDLE.
  - Move/door counters=0, last direction=UP.
- Pending update each cycle: `pending_next = (pending | req) & ~clr`.
  - `clr` is the one-hot mask of `floor` on any cycle that enters DOOR, or that stays in DOOR.
  - Clear wins over a simultaneous set for the current floor.
  - Calls for the current floor while the doors are open are therefore dropped.
- `above` = any pending bit with index > `floor`; `below` = any pending bit with index < `floor`.
- IDLE (evaluated every cycle, not gated by `tick`):
  - `pending[floor]` (including a `req` arriving this cycle) → DOOR.
  - else `above` → UP.
  - else `below` → DOWN.
  - else stay in IDLE.
- UP / DOWN:
  - On each `tick`, the move counter increments.
  - When it reaches `MOVE_TICKS` it resets to 0 and `floor` steps ±1. On that same edge:
    - If the new floor is pending → DOOR.
    - Otherwise stay in UP/DOWN.
  - Last direction is recorded on entry.
  - `floor` must never go below 0 or above `FLOORS-1`. The car only moves toward a pending bit, and bits are cleared only in DOOR, so the target always persists.
- DOOR:
  - Each `tick` increments the door counter. At `DOOR_TICKS` the counter resets and the next state is chosen as follows.
  - Continue in the last direction if there are requests that way (`above` for UP, `below` for DOWN).
  - Else reverse if there are requests the other way.
  - Else IDLE.
- `destination` = `pending` register; `sim_state` = state register.

## Timing
- All outputs are registered. Changes appear one edge after the qualifying input.
- A `req` bit sampled at edge N appears in `destination` after edge N.
  - Exception: the bit is already being cleared (same floor in DOOR), in which case it never appears.
- IDLE to UP/DOWN/DOOR takes 1 cycle from the request edge.
- Floor-to-floor travel takes exactly `MOVE_TICKS` ticks. The door dwell takes exactly `DOOR_TICKS` ticks.
- `tick` is ignored in IDLE. A `tick` coinciding with a state transition out of IDLE is not counted.
- Counters reset whenever the state changes.

## Test plan
- Reset mid-move: reset at floor 3 in UP, then `rst`=0 for one edge → `floor`=0, `destination`=0, `sim_state`=00 on the following cycle.
- Single call up: from reset, pulse `req`=8'h08 for one cycle, `tick` every 4 clocks.
  - `sim_state`=01 for 6 ticks (3 floors × `MOVE_TICKS` 2).
  - `floor` steps 1, 2, 3.
  - Then 11 with `destination`=0, then 00 after 4 ticks.
- Same-floor call: IDLE at floor 0, `req`=8'h01 → `sim_state`=11 next cycle, `destination` bit never set. Holding `req`=8'h01 during DOOR keeps `destination`=0.
- Direction preference: car at floor 4 moving UP, `pending`=8'h81 (floors 0 and 7).
  - Car stops at 7 (DOOR).
  - Then DOWN to 0 with no stop in between.
  - Then DOOR, then IDLE.
- Mid-travel call: while moving UP from 0 toward 6, `req`=8'h08 is asserted before the car reaches floor 3 → car stops at 3, then continues UP to 6.
- Simultaneous set/clear: on the DOOR-entry edge at floor 2, `req`=8'h24 → `destination`=8'h20 (bit 2 cleared, bit 5 set).
